// File: rtl/l2_bus_ctrl.sv
// l2_bus_ctrl: bus-operation controller downstream of the L2 cache.
// Takes one line-level request (READ, WRITE, INVALIDATE, RFO), issues it on
// the system bus with a valid/ack handshake, re-issues READ/RFO after a
// backoff when another cache reports HITM, and hands the final snoop result
// back to the L2.
// Optional feature macro: BUS_TIMEOUT_EN (abort a bus command that is never
// acknowledged within TIMEOUT_CYC cycles).

module l2_bus_ctrl #(
   parameter int ADDR_SIZE   = 32,
   parameter int OFFSET_SIZE = 6,
   parameter int MAX_RETRY   = 3,
   parameter int BACKOFF_CYC = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [1:0]           req_op,
   input  logic [ADDR_SIZE-1:0] req_addr,
   output logic                 bus_cmd_valid,
   output logic [1:0]           bus_cmd,
   output logic [ADDR_SIZE-1:0] bus_addr,
   input  logic                 bus_ack,
   input  logic [1:0]           snoop_in,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [1:0]           rsp_snoop,
   output logic                 rsp_err,
   output logic [15:0]          rd_count,
   output logic [15:0]          hitm_count
);

   typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_t;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_RFO   = 2'b11;
   localparam logic [1:0] SN_HITM  = 2'b01;
   localparam logic [1:0] SN_NOHIT = 2'b10;

   localparam logic [ADDR_SIZE-1:0] OFF_MASK  = ADDR_SIZE'((64'd1 << OFFSET_SIZE) - 64'd1);
   localparam logic [7:0]           RETRY_MAX = 8'(MAX_RETRY);
   localparam logic [15:0]          BO_LAST   = 16'(BACKOFF_CYC - 1);

   state_t      state;
   logic [7:0]  retry_cnt;
   logic [15:0] bo_cnt;
   logic        is_read;
   logic        ack;
   logic        hitm;
   logic [1:0]  snoop_norm;

`ifdef BUS_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
   logic [15:0] to_cnt;
`endif

   // Decode the latched op and the incoming snoop; reserved snoop code reads as NOHIT
   always_comb begin
      is_read    = (bus_cmd == OP_READ) || (bus_cmd == OP_RFO);
      ack        = bus_ack && bus_cmd_valid;
      hitm       = (snoop_in == SN_HITM);
      snoop_norm = (snoop_in == 2'b11) ? SN_NOHIT : snoop_in;
   end

   // Main controller FSM; every output is a register updated here
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         req_ready     <= 1'b0;
         bus_cmd_valid <= 1'b0;
         bus_cmd       <= 2'b00;
         bus_addr      <= '0;
         rsp_valid     <= 1'b0;
         rsp_snoop     <= 2'b00;
         rsp_err       <= 1'b0;
         rd_count      <= 16'h0000;
         hitm_count    <= 16'h0000;
         retry_cnt     <= 8'h00;
         bo_cnt        <= 16'h0000;
`ifdef BUS_TIMEOUT_EN
         to_cnt        <= 16'h0000;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  bus_cmd       <= req_op;
                  bus_addr      <= req_addr & ~OFF_MASK;
                  retry_cnt     <= 8'h00;
                  bus_cmd_valid <= 1'b1;
                  req_ready     <= 1'b0;
`ifdef BUS_TIMEOUT_EN
                  to_cnt        <= 16'h0000;
`endif
                  state         <= BUS;
               end else begin
                  req_ready <= 1'b1;
               end
            end

            BUS: begin
               if (ack) begin
                  if (hitm && hitm_count != 16'hFFFF)
                     hitm_count <= hitm_count + 16'd1;
                  bus_cmd_valid <= 1'b0;
                  if (is_read && hitm) begin
                     if (retry_cnt < RETRY_MAX) begin
                        retry_cnt <= retry_cnt + 8'd1;
                        bo_cnt    <= 16'h0000;
                        state     <= BACKOFF;
                     end else begin
                        rsp_snoop <= SN_HITM;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                     end
                  end else begin
                     rsp_snoop <= snoop_norm;
                     rsp_err   <= 1'b0;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end
               end
`ifdef BUS_TIMEOUT_EN
               else if (to_cnt == TO_LAST) begin
                  bus_cmd_valid <= 1'b0;
                  rsp_snoop     <= SN_NOHIT;
                  rsp_err       <= 1'b1;
                  rsp_valid     <= 1'b1;
                  state         <= RESP;
               end else begin
                  to_cnt <= to_cnt + 16'd1;
               end
`endif
            end

            BACKOFF: begin
               if (bo_cnt == BO_LAST) begin
                  bus_cmd_valid <= 1'b1;
`ifdef BUS_TIMEOUT_EN
                  to_cnt        <= 16'h0000;
`endif
                  state         <= BUS;
               end else begin
                  bo_cnt <= bo_cnt + 16'd1;
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  if (is_read && !rsp_err && rd_count != 16'hFFFF)
                     rd_count <= rd_count + 16'd1;
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l2_bus_ctrl.sv
// tb_l2_bus_ctrl: self-checking bench for l2_bus_ctrl.
// Single-ack transactions come from a vector table; retry, retry exhaustion,
// reset during backoff and the unacknowledged-command case are hand sequences.
// Expected responses go into a scoreboard queue when a request is driven and
// are popped when the controller raises rsp_valid.

module tb_l2_bus_ctrl;

   localparam int BACKOFF = 4;
   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_addr;
   logic        bus_cmd_valid;
   logic [1:0]  bus_cmd;
   logic [31:0] bus_addr;
   logic        bus_ack;
   logic [1:0]  snoop_in;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_snoop;
   logic        rsp_err;
   logic [15:0] rd_count;
   logic [15:0] hitm_count;

   typedef struct {
      logic [1:0] op;
      logic [1:0] snoop;
      logic       err;
   } rsp_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] addr;
      int          delay;
      logic [1:0]  snoop;
      logic [31:0] expAddr;
      logic [1:0]  expSnoop;
      logic        expErr;
   } vec_t;

   rsp_t sbQ[$];
   vec_t vecs[5];

   int testsRun    = 0;
   int testsFailed = 0;
   int expRd       = 0;
   int expHitm     = 0;

   l2_bus_ctrl #(
      .ADDR_SIZE(32), .OFFSET_SIZE(6), .MAX_RETRY(3),
      .BACKOFF_CYC(BACKOFF), .TIMEOUT_CYC(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
      .bus_cmd_valid(bus_cmd_valid), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
      .bus_ack(bus_ack), .snoop_in(snoop_in),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_snoop(rsp_snoop), .rsp_err(rsp_err),
      .rd_count(rd_count), .hitm_count(hitm_count)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Hard stop in case a sequence wedges
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_req_ready"},     req_ready,     1'b0);
      check({tag, "_bus_cmd_valid"}, bus_cmd_valid, 1'b0);
      check({tag, "_bus_cmd"},       bus_cmd,       2'b00);
      check({tag, "_bus_addr"},      bus_addr,      32'h0);
      check({tag, "_rsp_valid"},     rsp_valid,     1'b0);
      check({tag, "_rsp_snoop"},     rsp_snoop,     2'b00);
      check({tag, "_rsp_err"},       rsp_err,       1'b0);
      check({tag, "_rd_count"},      rd_count,      16'h0);
      check({tag, "_hitm_count"},    hitm_count,    16'h0);
   endtask

   // Wait for a response, compare it to the scoreboard head, then consume it
   task automatic checkOutput();
      rsp_t e;
      int   n = 0;
      while (!rsp_valid && n < 200) begin
         tick();
         n++;
      end
      check("rsp_valid_wait", rsp_valid, 1'b1);
      check("sb_has_entry", sbQ.size() != 0, 1'b1);
      if (sbQ.size() == 0) return;
      e = sbQ.pop_front();
      check("rsp_snoop", rsp_snoop, e.snoop);
      check("rsp_err", rsp_err, e.err);
      tick();
      check("rsp_hold", {rsp_valid, rsp_snoop, rsp_err}, {1'b1, e.snoop, e.err});
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      if ((e.op == 2'b00 || e.op == 2'b11) && !e.err) expRd++;
      check("rsp_drop", rsp_valid, 1'b0);
      check("req_ready_after_rsp", req_ready, 1'b1);
      check("rd_count", rd_count, 32'(expRd));
      check("hitm_count", hitm_count, 32'(expHitm));
   endtask

   // Issue one request and answer nAcks bus commands with the given snoops
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr,
                                input logic [31:0] expAddr, input int nAcks,
                                input logic [7:0] snoops, input int delay,
                                input logic [1:0] expSnoop, input logic expErr);
      int n = 0;
      sbQ.push_back('{op, expSnoop, expErr});
      req_op    = op;
      req_addr  = addr;
      req_valid = 1'b1;
      while (!bus_cmd_valid && n < 20) begin
         tick();
         n++;
      end
      req_valid = 1'b0;
      check("cmd_valid_wait", bus_cmd_valid, 1'b1);
      check("req_ready_busy", req_ready, 1'b0);
      for (int i = 0; i < nAcks; i++) begin
         logic [1:0] s;
         int         lowCnt;
         s = snoops[2*i +: 2];
         check("bus_addr", bus_addr, expAddr);
         check("bus_cmd", bus_cmd, op);
         repeat (delay) tick();
         check("cmd_held", bus_cmd_valid, 1'b1);
         bus_ack  = 1'b1;
         snoop_in = s;
         tick();
         bus_ack  = 1'b0;
         snoop_in = 2'b00;
         if (s == 2'b01) expHitm++;
         if (i < nAcks - 1) begin
            lowCnt = 0;
            while (!bus_cmd_valid && lowCnt < 50) begin
               tick();
               lowCnt++;
            end
            check("backoff_len", 32'(lowCnt), 32'(BACKOFF));
         end else begin
            check("rsp_latency", rsp_valid, 1'b1);
         end
      end
      checkOutput();
   endtask

   initial begin
      int n;
      vecs[0] = '{2'b00, 32'h1234_5678, 3, 2'b10, 32'h1234_5640, 2'b10, 1'b0};
      vecs[1] = '{2'b01, 32'hDEAD_BEEF, 0, 2'b01, 32'hDEAD_BEC0, 2'b01, 1'b0};
      vecs[2] = '{2'b10, 32'h0000_003F, 1, 2'b00, 32'h0000_0000, 2'b00, 1'b0};
      vecs[3] = '{2'b11, 32'hFFFF_FFFF, 2, 2'b11, 32'hFFFF_FFC0, 2'b10, 1'b0};
      vecs[4] = '{2'b00, 32'h8000_0041, 0, 2'b00, 32'h8000_0040, 2'b00, 1'b0};

      rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = 32'h0;
      bus_ack = 1'b0; snoop_in = 2'b00; rsp_ready = 1'b0;
      repeat (3) tick();
      checkAllZero("reset");
      rst = 1'b0;
      tick();
      check("req_ready_after_reset", req_ready, 1'b1);

      // Ack while no command is on the bus must be ignored
      bus_ack = 1'b1; snoop_in = 2'b01;
      tick();
      bus_ack = 1'b0; snoop_in = 2'b00;
      tick();
      check("stray_ack_hitm", hitm_count, 16'h0);
      check("stray_ack_rsp", rsp_valid, 1'b0);

      foreach (vecs[i])
         applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].expAddr, 1,
                       {6'b0, vecs[i].snoop}, vecs[i].delay,
                       vecs[i].expSnoop, vecs[i].expErr);

      // RFO hits HITM once, then HIT on the re-issue
      applyStimulus(2'b11, 32'h0000_1008, 32'h0000_1000, 2, 8'h01, 1, 2'b00, 1'b0);

      // READ sees HITM on every ack until retries run out
      applyStimulus(2'b00, 32'h0000_2000, 32'h0000_2000, 4, 8'h55, 0, 2'b01, 1'b1);

      // Unacknowledged command
      sbQ.push_back('{2'b00, 2'b10, 1'b1});
      req_op = 2'b00; req_addr = 32'h0000_0100; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      check("to_cmd_valid", bus_cmd_valid, 1'b1);
`ifdef BUS_TIMEOUT_EN
      n = 0;
      while (!rsp_valid && n < 200) begin
         tick();
         n++;
      end
      check("timeout_len", 32'(n), 32'(TIMEOUT));
      checkOutput();
`else
      n = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (bus_cmd_valid && !rsp_valid) n++;
      end
      check("cmd_held_200", 32'(n), 32'd200);
      sbQ[sbQ.size()-1].err = 1'b0;
      bus_ack = 1'b1; snoop_in = 2'b10;
      tick();
      bus_ack = 1'b0; snoop_in = 2'b00;
      checkOutput();
`endif

      // Reset in the middle of a backoff
      req_op = 2'b00; req_addr = 32'h0000_3000; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      bus_ack = 1'b1; snoop_in = 2'b01;
      tick();
      bus_ack = 1'b0; snoop_in = 2'b00;
      tick();
      check("in_backoff", bus_cmd_valid, 1'b0);
      rst = 1'b1; rsp_ready = 1'b1;
      tick();
      checkAllZero("mid_reset");
      rst = 1'b0;
      expRd = 0; expHitm = 0;
      tick();
      check("req_ready_after_abort", req_ready, 1'b1);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (rsp_valid || bus_cmd_valid) n++;
      end
      check("no_rsp_after_abort", 32'(n), 32'd0);
      rsp_ready = 1'b0;

      // Controller still works after the abort
      applyStimulus(2'b00, 32'h0000_4010, 32'h0000_4000, 1, 8'h02, 0, 2'b10, 1'b0);

      check("sb_drained", 32'(sbQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
